rsa_mont_arbiter: RTL and testbench
===================================

# rsa_mont_arbiter

Round-robin arbiter and sequencer that shares one RSAMont modular-exponentiation engine between `N_REQ` independent requesters.

- Sits between the requester-side valid/ready ports and the single engine instance.
- Grants the engine to one requester, forwards that requester's `RSAMontModIn` job, and holds the grant through the whole exponentiation.
- Routes the `RSAMontModOut` result back to the granted requester only, then re-arbitrates.
- Only one job is in flight at a time; the arbiter never interleaves jobs.

## Interface

Parameters:
- `N_REQ`, default 4: number of requesters; legal range 2..16.
- `GRANT_W`, default `$clog2(N_REQ)`: width of the grant index.

Ports (clock and reset first):
- `clk`  input  1  single clock; all logic on rising edge.
- `rst_n`  input  1  reset, synchronous and active-low.
- `i_valid`  input  N_REQ  per-requester job valid.
- `i_ready`  output  N_REQ  per-requester job accept.
- `i_in`  input  N_REQ × RSAMontModIn  per-requester job payload.
- `o_valid`  output  N_REQ  per-requester result valid.
- `o_ready`  input  N_REQ  per-requester result accept.
- `o_out`  output  RSAMontModOut  result; broadcast to all requesters, qualified by `o_valid`.
- `eng_i_valid`  output  1  job valid to engine.
- `eng_i_ready`  input  1  engine accepts job.
- `eng_i_in`  output  RSAMontModIn  job to engine.
- `eng_o_valid`  input  1  engine result valid.
- `eng_o_ready`  output  1  arbiter accepts result.
- `eng_o_out`  input  RSAMontModOut  engine result.
- `o_busy`  output  1  high whenever state ≠ IDLE.
- `o_grant`  output  GRANT_W  registered index of the current or last grant.

## Operation

State machine:
- **IDLE**
  - If any `i_valid` is high: select a winner, register it into `o_grant`, go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE**
  - Drives `eng_i_valid = i_valid[o_grant]`, `eng_i_in = i_in[o_grant]` and `i_ready[o_grant] = eng_i_ready`.
  - On the `eng_i_valid && eng_i_ready` handshake, go to WAIT.
  - If `i_valid[o_grant]` drops before that handshake (protocol violation), return to IDLE with no handshake; the pointer is unchanged.
- **WAIT**
  - Drives `o_valid[o_grant] = eng_o_valid` and `eng_o_ready = o_ready[o_grant]`.
  - On the result handshake, set the pointer to `(o_grant+1) mod N_REQ` and go to IDLE.

Output rules:
- All `i_ready` and `o_valid` bits of non-granted requesters are 0 in every state.
- `eng_i_valid` is 0 outside ISSUE; `eng_o_ready` is 0 outside WAIT.
- `eng_i_in` equals `i_in[o_grant]` in every state; it is qualified only by `eng_i_valid`.
- `o_out = eng_o_out`, a pass-through with no register.

Round-robin selection:
- The winner is the first `i` with `i_valid[i]` high, scanning `pointer`, `pointer+1`, … with wrap modulo `N_REQ`.
- The pointer is a `GRANT_W`-bit register, reset to 0, updated only on a result handshake.

## Timing

Reset (`rst_n` low at a clock edge):
- State IDLE, pointer 0, `o_grant` 0, `o_busy` 0.
- All `i_ready`, `o_valid`, `eng_i_valid` and `eng_o_ready` are 0.

Latency:
- A request seen in IDLE at edge t gives grant and ISSUE from t+1.
- `eng_i_valid` is therefore high in cycle t+1 at the earliest.
- A result handshake in cycle u gives IDLE at u+1, re-arbitration in u+1, and the next `eng_i_valid` in u+2.
- Minimum 2-cycle gap between engine jobs.

Handshake and boundary rules:
- Requests arriving during ISSUE or WAIT are held off (`i_ready` = 0) and arbitrated at the next IDLE.
- Backpressure: `o_ready[o_grant]` low holds WAIT indefinitely with `eng_o_ready` = 0.
- Pointer wrap: a grant to `N_REQ-1` sets the pointer to 0.
- Reset mid-operation returns to IDLE regardless of state.
  - The engine must share `rst_n` so no stale result arrives.
  - Any `eng_o_valid` seen in IDLE or ISSUE is ignored (`eng_o_ready` = 0).

## Configuration

- `RSA_ARB_FIXED_PRIO_EN` defined: fixed priority.
  - The lowest asserted index always wins.
  - The pointer register is removed and `o_grant` selection ignores history.
- Not defined (default): round-robin as specified in Operation.
- All other behaviour is identical in both builds.

## Test plan

The bench drives an engine stub with fixed latency 10 cycles after the input handshake; the stub returns `msg+1` in the result.

- Single job: requester 2 sends `msg=5` at reset+2.
  - `eng_i_valid` rises 1 cycle later with `eng_i_in.msg=5`.
  - `o_valid[2]` rises with `o_out=6`.
  - All other `o_valid`/`i_ready` bits stay 0 throughout.
- Round-robin: requesters 0, 1 and 3 all hold valid from cycle 0.
  - Grant order is 0, 1, 3, 0.
  - `o_grant` matches the order; gap between engine jobs is 2 cycles.
- Fixed priority (macro defined): same stimulus as the round-robin test.
  - Grant order is 0, 0, 0 while requester 0 keeps re-requesting.
  - Requesters 1 and 3 are served only after 0 drops.
- Backpressure: hold `o_ready[1]` low 20 cycles after `o_valid[1]` rises.
  - The arbiter stays in WAIT with `eng_o_ready=0` and `o_busy=1`.
  - The result is accepted on the first `o_ready[1]` high.
  - No other requester is granted meanwhile.
- Reset mid-WAIT: assert `rst_n=0` 5 cycles into a job.
  - Next edge: `o_busy=0`, `o_grant=0`, all handshake outputs 0.
  - A new request is granted normally after `rst_n` rises.
- Pointer wrap: with `N_REQ=4`, grant requester 3, then all four request.
  - The next grant is 0.

Source files
------------

// File: rtl/rsa_mont_arbiter.sv
// ============================================================================
// Module   : rsa_mont_arbiter
// Purpose  : Shares one RSAMont engine between N_REQ requesters, one job at a
//            time. Round-robin by default; RSA_ARB_FIXED_PRIO_EN selects
//            fixed lowest-index priority.
// Revision : 1.0
// ============================================================================
`default_nettype none

package rsa_mont_pkg;
  typedef struct packed {
    logic [31:0] msg;
    logic [31:0] exponent;
    logic [31:0] modulus;
  } RSAMontModIn;

  typedef struct packed {
    logic [31:0] result;
  } RSAMontModOut;
endpackage

module rsa_mont_arbiter
  import rsa_mont_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int GRANT_W = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          i_valid,
  output logic [N_REQ-1:0]          i_ready,
  input  RSAMontModIn [N_REQ-1:0]   i_in,
  output logic [N_REQ-1:0]          o_valid,
  input  logic [N_REQ-1:0]          o_ready,
  output RSAMontModOut              o_out,
  output logic                      eng_i_valid,
  input  logic                      eng_i_ready,
  output RSAMontModIn               eng_i_in,
  input  logic                      eng_o_valid,
  output logic                      eng_o_ready,
  input  RSAMontModOut              eng_o_out,
  output logic                      o_busy,
  output logic [GRANT_W-1:0]        o_grant
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic [GRANT_W-1:0] c_last = GRANT_W'(N_REQ - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [GRANT_W-1:0] r_grant;
  logic [GRANT_W-1:0] w_winner;
  logic               w_res_hs;

  assign w_res_hs = eng_o_valid & eng_o_ready;

`ifdef RSA_ARB_FIXED_PRIO_EN
  // Descending scan so the lowest asserted index is the last write.
  always_comb begin
    w_winner = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (i_valid[k]) w_winner = GRANT_W'(k);
    end
  end
`else
  localparam int IW = GRANT_W + 1;

  logic [GRANT_W-1:0] r_ptr;
  logic [IW-1:0]      w_idx;

  // Scan ptr+N-1 down to ptr so the first valid at/after the pointer wins.
  always_comb begin
    w_winner = r_ptr;
    w_idx    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_ptr} + IW'(k);
      if (w_idx >= IW'(N_REQ)) w_idx = w_idx - IW'(N_REQ);
      if (i_valid[w_idx[GRANT_W-1:0]]) w_winner = w_idx[GRANT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_res_hs) begin
      r_ptr <= (r_grant == c_last) ? '0 : r_grant + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && |i_valid) r_grant <= w_winner;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    i_ready     = '0;
    o_valid     = '0;
    eng_i_valid = 1'b0;
    eng_o_ready = 1'b0;
    eng_i_in    = i_in[r_grant];
    case (r_state)
      ST_IDLE: begin
        if (|i_valid) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        eng_i_valid      = i_valid[r_grant];
        i_ready[r_grant] = eng_i_ready;
        // A requester withdrawing before acceptance abandons the slot.
        if (eng_i_valid && eng_i_ready) w_state_nxt = ST_WAIT;
        else if (!i_valid[r_grant])     w_state_nxt = ST_IDLE;
      end
      ST_WAIT: begin
        o_valid[r_grant] = eng_o_valid;
        eng_o_ready      = o_ready[r_grant];
        if (w_res_hs) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_out   = eng_o_out;
  assign o_busy  = (r_state != ST_IDLE);
  assign o_grant = r_grant;

endmodule

`default_nettype wire

// File: tb/tb_rsa_mont_arbiter.sv
// Bench for rsa_mont_arbiter: engine stub (10-cycle latency, result = msg+1)
// and a scan-based round-robin / fixed-priority reference model.
`default_nettype none

module tb_rsa_mont_arbiter;
  import rsa_mont_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]       i_valid, i_ready, o_valid, o_ready;
  RSAMontModIn [N-1:0] i_in;
  RSAMontModOut       o_out, eng_o_out;
  RSAMontModIn        eng_i_in;
  logic               eng_i_valid, eng_i_ready, eng_o_valid, eng_o_ready, o_busy;
  logic [1:0]         o_grant;

  rsa_mont_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .i_ready(i_ready), .i_in(i_in),
    .o_valid(o_valid), .o_ready(o_ready), .o_out(o_out),
    .eng_i_valid(eng_i_valid), .eng_i_ready(eng_i_ready), .eng_i_in(eng_i_in),
    .eng_o_valid(eng_o_valid), .eng_o_ready(eng_o_ready), .eng_o_out(eng_o_out),
    .o_busy(o_busy), .o_grant(o_grant)
  );

  // Engine stub: accepts when idle, answers msg+1 ten cycles after acceptance.
  logic eng_busy;
  int   eng_cnt;
  assign eng_i_ready = !eng_busy;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      eng_busy    <= 1'b0;
      eng_cnt     <= 0;
      eng_o_valid <= 1'b0;
      eng_o_out   <= '0;
    end else if (!eng_busy) begin
      if (eng_i_valid) begin
        eng_busy         <= 1'b1;
        eng_cnt          <= 10;
        eng_o_out.result <= eng_i_in.msg + 32'd1;
      end
    end else if (eng_o_valid) begin
      if (eng_o_ready) begin
        eng_o_valid <= 1'b0;
        eng_busy    <= 1'b0;
      end
    end else if (eng_cnt == 1) begin
      eng_o_valid <= 1'b1;
    end else begin
      eng_cnt <= eng_cnt - 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_res_cyc = 0;
  int ptr      = 0;
  logic [31:0] msg [N];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_msg(input int k);
    msg[k] = $urandom;
    i_in[k].msg = msg[k];
  endtask

  // Reference arbitration: first requester at or after the pointer, wrapping.
  function automatic int model_winner(input logic [N-1:0] m);
`ifdef RSA_ARB_FIXED_PRIO_EN
    for (int k = 0; k < N; k++) if (m[k]) return k;
`else
    for (int k = 0; k < N; k++) if (m[(ptr + k) % N]) return (ptr + k) % N;
`endif
    return -1;
  endfunction

  task automatic do_job(input int w, input int hold, input bit keep,
                        input int exp_lat, input int exp_gap);
    int waited = 0;
    logic [31:0] exp_res;
    while (!eng_i_valid && waited < 40) begin step(); waited++; end
    check("issue_seen", eng_i_valid, 1);
    if (exp_lat >= 0) check("issue_latency", waited, exp_lat);
    if (exp_gap >= 0) check("job_gap", cyc - last_res_cyc, exp_gap);
    check("grant", o_grant, w);
    check("busy_issue", o_busy, 1);
    check("eng_msg", eng_i_in.msg, msg[w]);
    check("i_ready_issue", i_ready, 1 << w);
    check("o_valid_issue", o_valid, 0);
    exp_res = msg[w] + 32'd1;
    step();
    if (keep) set_msg(w);
    else i_valid[w] = 1'b0;
    waited = 0;
    while (o_valid == '0 && waited < 40) begin step(); waited++; end
    check("o_valid", o_valid, 1 << w);
    check("o_out", o_out.result, exp_res);
    check("i_ready_wait", i_ready, 0);
    if (hold > 0) begin
      o_ready[w] = 1'b0;
      i_valid = i_valid | (N'($urandom) & ~N'(1 << w));
      repeat (hold) begin
        step();
        check("bp_eng_o_ready", eng_o_ready, 0);
        check("bp_busy", o_busy, 1);
        check("bp_grant", o_grant, w);
        check("bp_i_ready", i_ready, 0);
      end
      check("bp_o_valid", o_valid, 1 << w);
      o_ready[w] = 1'b1;
      #1;
    end
    check("eng_o_ready", eng_o_ready, 1);
    last_res_cyc = cyc;
    step();
    check("busy_after", o_busy, 0);
    check("o_valid_after", o_valid, 0);
    ptr = (w + 1) % N;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    ptr = 0;
  endtask

  initial begin
    int order [4];
    int w;
`ifdef RSA_ARB_FIXED_PRIO_EN
    order = '{0, 0, 0, 0};
`else
    order = '{0, 1, 3, 0};
`endif
    i_valid = '0;
    o_ready = '1;
    for (int k = 0; k < N; k++) begin
      i_in[k] = '{msg: 32'd0, exponent: $urandom, modulus: $urandom};
      set_msg(k);
    end

    // Reset state
    step();
    step();
    check("rst_busy", o_busy, 0);
    check("rst_grant", o_grant, 0);
    check("rst_i_ready", i_ready, 0);
    check("rst_o_valid", o_valid, 0);
    check("rst_eng_i_valid", eng_i_valid, 0);
    check("rst_eng_o_ready", eng_o_ready, 0);
    rst_n = 1'b1;
    step();

    // Single job from requester 2
    msg[2] = 32'd5;
    i_in[2].msg = 32'd5;
    i_valid[2] = 1'b1;
    do_job(2, 0, 1'b0, 1, -1);

    // Three requesters holding valid from reset
    do_reset();
    i_valid = 4'b1011;
    for (int j = 0; j < 4; j++) do_job(order[j], 0, 1'b1, -1, (j == 0) ? -1 : 2);
    i_valid[0] = 1'b0;
    for (int j = 0; j < 2; j++) do_job(model_winner(i_valid), 0, 1'b0, -1, 2);

    // Backpressure on requester 1
    i_valid = '0;
    step();
    i_valid[1] = 1'b1;
    do_job(1, 20, 1'b0, 1, -1);
    while (i_valid != '0) do_job(model_winner(i_valid), 0, 1'b0, -1, 2);

    // Pointer wrap
    do_reset();
    i_valid = 4'b1000;
    do_job(3, 0, 1'b0, 1, -1);
    i_valid = 4'b1111;
    do_job(0, 0, 1'b0, -1, 2);

    // Reset in the middle of a job
    begin
      int waited = 0;
      while (!eng_i_valid && waited < 40) begin step(); waited++; end
      check("mid_issue_seen", eng_i_valid, 1);
      repeat (6) step();
      check("mid_busy", o_busy, 1);
      rst_n = 1'b0;
      step();
      check("mid_rst_busy", o_busy, 0);
      check("mid_rst_grant", o_grant, 0);
      check("mid_rst_i_ready", i_ready, 0);
      check("mid_rst_o_valid", o_valid, 0);
      check("mid_rst_eng_i_valid", eng_i_valid, 0);
      check("mid_rst_eng_o_ready", eng_o_ready, 0);
      rst_n = 1'b1;
      ptr = 0;
    end
    do_job(model_winner(i_valid), 0, 1'b0, 1, -1);

    // Randomised traffic against the reference model
    for (int it = 0; it < 16; it++) begin
      if (i_valid == '0) begin
        i_valid = N'($urandom_range(1, (1 << N) - 1));
        for (int k = 0; k < N; k++) if (i_valid[k]) set_msg(k);
      end
      w = model_winner(i_valid);
      do_job(w, $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
